// File: rtl/run_length_decoder.sv
// Run-length decoder: buffers valid-only code words in a FIFO and expands
// literals and marker/count pairs into symbols on a valid/ready output.
module run_length_decoder #(
    parameter int unsigned SIZE       = 7,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SIZE:0]   in_data,
    input  logic            in_valid,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overflow,
    output logic            busy
);

    localparam int unsigned W  = SIZE + 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        CNT   = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_n;
    logic [SIZE-1:0] sym, sym_n;
    logic [W-1:0]    rem, rem_n;
    logic [W-1:0]    head;
    logic [SIZE-1:0] load_data;
    logic            full, empty, pop, wr_en, drop, load, load_ok, beat, valid_n;

    assign head    = mem[rd_ptr];
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign beat    = out_valid & out_ready;
    assign load_ok = ~out_valid | out_ready;

    // Decode FSM plus FIFO bookkeeping; a write is only poppable the cycle after it lands.
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        load      = 1'b0;
        load_data = sym;
        sym_n     = sym;
        rem_n     = rem;
        unique case (state)
            FETCH: begin
                if (load_ok && !empty) begin
                    pop = 1'b1;
                    if (head[SIZE]) begin
                        sym_n   = head[SIZE-1:0];
                        state_n = CNT;
                    end else if (head[SIZE-1:0] != '0) begin
                        load      = 1'b1;
                        load_data = head[SIZE-1:0];
                    end
                end
            end
            CNT: begin
                if (load_ok && !empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    rem_n   = head;
                    state_n = (head == '0) ? FETCH : RUN;
                end
            end
            RUN: begin
                if (beat) begin
                    load  = 1'b1;
                    rem_n = rem - W'(1);
                    if (rem == W'(1)) state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase

        wr_en   = in_valid & (~full | pop);
        drop    = in_valid & full & ~pop;
        count_n = count + CW'(wr_en) - CW'(pop);
        valid_n = load | (out_valid & ~out_ready);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sym       <= '0;
            rem       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (drop)  overflow <= 1'b1;
            if (load)  out_data <= load_data;
            count     <= count_n;
            sym       <= sym_n;
            rem       <= rem_n;
            out_valid <= valid_n;
            busy      <= (count_n != '0) | (state_n != FETCH) | valid_n;
        end
    end

endmodule

// File: tb/tb_run_length_decoder.sv
// Self-checking bench for run_length_decoder: directed table, corner sequences
// and randomized chunks compared against a stream-level decode model.
module tb_run_length_decoder;

    localparam int unsigned SIZE  = 7;
    localparam int unsigned DEPTH = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [SIZE:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            overflow;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    bit rand_ready = 1'b0;
    bit hold_pend = 1'b0;
    logic [SIZE-1:0] hold_data;
    logic [SIZE-1:0] exp_q[$];

    typedef struct {
        logic [7:0] w0;
        logic [7:0] w1;
        logic [6:0] sym;
        int         beats;
    } vec_t;
    vec_t vecs[7];

    run_length_decoder #(.SIZE(SIZE), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        in_data  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    // Stream-level reference: literals, skipped zero words, marker + count -> N+1 copies.
    function automatic void model(input logic [7:0] words[$]);
        int i = 0;
        while (i < words.size()) begin
            logic [7:0] w = words[i];
            if (w[7]) begin
                for (int k = 0; k <= int'(words[i+1]); k++) exp_q.push_back(w[6:0]);
                i += 2;
            end else begin
                if (w != 8'h00) exp_q.push_back(w[6:0]);
                i += 1;
            end
        end
    endfunction

    always @(posedge clock) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: every beat against the expected queue; stalled data must hold.
    always @(negedge clock) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), int'(hold_data));
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) check("extra_beat", int'(out_data), -1);
                else check("beat_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] words[$];

        vecs[0] = '{8'h8A, 8'h02, 7'h0A, 3};
        vecs[1] = '{8'h81, 8'hFF, 7'h01, 256};
        vecs[2] = '{8'h83, 8'h00, 7'h03, 1};
        vecs[3] = '{8'h84, 8'h80, 7'h04, 129};
        vecs[4] = '{8'h05, 8'h00, 7'h05, 1};
        vecs[5] = '{8'h00, 8'h12, 7'h12, 1};
        vecs[6] = '{8'hFF, 8'h01, 7'h7F, 2};

        step();
        step();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        step();

        // Literal latency and back-to-back throughput
        exp_q.push_back(7'h05);
        exp_q.push_back(7'h12);
        in_data = 8'h05; in_valid = 1'b1;
        step();
        check("lat_k_valid", int'(out_valid), 0);
        in_data = 8'h12;
        step();
        in_valid = 1'b0;
        check("lat_k1_valid", int'(out_valid), 1);
        check("lat_k1_data", int'(out_data), 'h05);
        step();
        check("lat_k2_valid", int'(out_valid), 1);
        check("lat_k2_data", int'(out_data), 'h12);
        step();
        check("lat_k3_valid", int'(out_valid), 0);
        wait_idle();

        for (int v = 0; v < 7; v++) begin
            beats_seen = 0;
            words = {};
            words.push_back(vecs[v].w0);
            words.push_back(vecs[v].w1);
            for (int k = 0; k < vecs[v].beats; k++) exp_q.push_back(vecs[v].sym);
            send(vecs[v].w0);
            send(vecs[v].w1);
            wait_idle();
            check($sformatf("vec%0d_beats", v), beats_seen, vecs[v].beats);
            check($sformatf("vec%0d_valid", v), int'(out_valid), 0);
            check($sformatf("vec%0d_left", v), exp_q.size(), 0);
        end

        // Zero word between literals is discarded
        beats_seen = 0;
        exp_q.push_back(7'h07);
        exp_q.push_back(7'h09);
        send(8'h07); send(8'h00); send(8'h09);
        wait_idle();
        check("zero_beats", beats_seen, 2);
        check("zero_overflow", int'(overflow), 0);

        // Stalled output fills the FIFO; one literal is dropped
        beats_seen = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back(7'h05);
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(7'(8'h20 + k));
        send(8'h85); send(8'h03);
        for (int k = 0; k <= DEPTH; k++) send(8'(8'h20 + k));
        step(); step(); step();
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), 'h05);
        check("stall_overflow", int'(overflow), 1);
        out_ready = 1'b1;
        wait_idle();
        check("stall_beats", beats_seen, 4 + DEPTH);
        check("stall_left", exp_q.size(), 0);

        // Reset during beat 2 of a 10-symbol run
        beats_seen = 0;
        for (int k = 0; k < 10; k++) exp_q.push_back(7'h09);
        send(8'h89); send(8'h09);
        for (int n = 0; n < 50 && beats_seen < 1; n++) step();
        check("mid_beats", beats_seen, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        check("mid_rst_busy", int'(busy), 0);
        exp_q.delete();
        beats_seen = 0;
        exp_q.push_back(7'h11);
        send(8'h11);
        wait_idle();
        check("post_rst_beats", beats_seen, 1);
        check("post_rst_left", exp_q.size(), 0);

        // Randomized chunks; each chunk fits the FIFO and keeps pairs whole
        rand_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            words = {};
            while (words.size() <= 14) begin
                int r = $urandom_range(0, 9);
                if (r < 5) begin
                    words.push_back(8'($urandom_range(1, 127)));
                end else if (r < 6) begin
                    words.push_back(8'h00);
                end else begin
                    words.push_back(8'h80 | 8'($urandom_range(0, 127)));
                    words.push_back((r == 9) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12)));
                end
            end
            model(words);
            foreach (words[i]) begin
                send(words[i]);
                repeat ($urandom_range(0, 2)) step();
            end
            wait_idle();
            check($sformatf("rand%0d_left", c), exp_q.size(), 0);
            check($sformatf("rand%0d_overflow", c), int'(overflow), 0);
            exp_q.delete();
        end
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
